// File: rtl/srai.sv
// srai: registered arithmetic right shift (log2 barrel), 1-cycle latency.
// Define SRAI_PIPE2_EN to split the barrel into two register stages (2-cycle latency).
module srai #(
   parameter int DATA_W  = 16,
   parameter int SHAMT_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] shift,
   input  logic [DATA_W-1:0] alu_in_1,
   output logic [DATA_W-1:0] alu_out,
   output logic              out_valid
);
   localparam int SPLIT = 2;
   logic [DATA_W-1:0]     lo [SPLIT+1];
   logic [DATA_W-1:0]     hi [SPLIT:SHAMT_W];
   logic [DATA_W-1:SPLIT] hi_shift;
   logic                  hi_sign;
   logic                  hi_valid;
   logic                  sat;
   assign lo[0] = alu_in_1;
   for (genvar k = 0; k < SPLIT; k++) begin : g_lo
      assign lo[k+1] = shift[k] ? {{(2**k){alu_in_1[DATA_W-1]}}, lo[k][DATA_W-1:2**k]} : lo[k];
   end
`ifdef SRAI_PIPE2_EN
   logic [DATA_W-1:0]     p_data;
   logic [DATA_W-1:SPLIT] p_shift;
   logic                  p_sign;
   logic                  p_valid;
   always_ff @(posedge clk) begin
      if (rst) begin
         p_data  <= '0;
         p_shift <= '0;
         p_sign  <= 1'b0;
         p_valid <= 1'b0;
      end else begin
         p_data  <= lo[SPLIT];
         p_shift <= shift[DATA_W-1:SPLIT];
         p_sign  <= alu_in_1[DATA_W-1];
         p_valid <= in_valid;
      end
   end
   assign hi[SPLIT] = p_data;
   assign hi_shift  = p_shift;
   assign hi_sign   = p_sign;
   assign hi_valid  = p_valid;
`else
   assign hi[SPLIT] = lo[SPLIT];
   assign hi_shift  = shift[DATA_W-1:SPLIT];
   assign hi_sign   = alu_in_1[DATA_W-1];
   assign hi_valid  = in_valid;
`endif
   for (genvar k = SPLIT; k < SHAMT_W; k++) begin : g_hi
      assign hi[k+1] = hi_shift[k] ? {{(2**k){hi_sign}}, hi[k][DATA_W-1:2**k]} : hi[k];
   end
   // any shift >= DATA_W leaves only sign copies
   assign sat = |hi_shift[DATA_W-1:SHAMT_W];
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_out   <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= hi_valid;
         if (hi_valid) alu_out <= sat ? {DATA_W{hi_sign}} : hi[SHAMT_W];
      end
   end
endmodule

// File: tb/tb_srai.sv
// tb_srai: directed self-checking bench for srai.
module tb_srai;
`ifdef SRAI_PIPE2_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] shift = '0;
   logic [15:0] alu_in_1 = '0;
   logic [15:0] alu_out;
   logic        out_valid;
   int          n_cmp = 0;
   int          n_err = 0;

   srai dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .shift(shift),
      .alu_in_1(alu_in_1), .alu_out(alu_out), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic op(input string tag, input logic [15:0] a, input logic [15:0] s, input logic [15:0] exp);
      @(negedge clk);
      in_valid = 1'b1;
      alu_in_1 = a;
      shift    = s;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      check({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
      check(tag, alu_out, exp);
   endtask

   logic [15:0] b_a [3] = '{16'h3ABD, 16'hC000, 16'h3ABD};
   logic [15:0] b_s [3] = '{16'd3, 16'd3, 16'd7};
   logic [15:0] b_e [3] = '{16'h0757, 16'hF800, 16'h0075};

   initial begin
      repeat (2) @(negedge clk);
      check("rst_out", alu_out, 16'h0000);
      check("rst_valid", {15'd0, out_valid}, 16'd0);
      rst = 1'b0;
      op("pos_s3", 16'h3ABD, 16'd3, 16'h0757);
      op("pos_s7", 16'h3ABD, 16'd7, 16'h0075);
      op("pos_s2", 16'h3ABD, 16'd2, 16'h0EAF);
      op("neg_s3", 16'hC000, 16'd3, 16'hF800);
      op("neg_s15", 16'h8001, 16'd15, 16'hFFFF);
      op("neg_s0", 16'hF0F0, 16'd0, 16'hF0F0);
      op("neg_s1", 16'hA5A5, 16'd1, 16'hD2D2);
      op("neg_s12", 16'hA5A5, 16'd12, 16'hFFFA);
      op("neg_s4", 16'h8000, 16'd4, 16'hF800);
      op("pos_s8", 16'h1234, 16'd8, 16'h0012);
      op("pos_s15", 16'h7FFF, 16'd15, 16'h0000);
      op("big_s16", 16'h8000, 16'd16, 16'hFFFF);
      op("big_s100", 16'h8000, 16'h0100, 16'hFFFF);
      op("big_ffff", 16'h8000, 16'hFFFF, 16'hFFFF);
      op("big_pos", 16'h3ABD, 16'd16, 16'h0000);
      op("big_8000", 16'h7FFF, 16'h8000, 16'h0000);
      for (int i = 0; i < 3 + LAT; i++) begin
         @(negedge clk);
         if (i >= LAT) begin
            check("b2b_valid", {15'd0, out_valid}, 16'd1);
            check("b2b_out", alu_out, b_e[i-LAT]);
         end
         if (i < 3) begin
            in_valid = 1'b1;
            alu_in_1 = b_a[i];
            shift    = b_s[i];
         end else in_valid = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         alu_in_1 = 16'h8000 + 16'(i);
         shift    = 16'(i + 1);
         check("hold_valid", {15'd0, out_valid}, 16'd0);
         check("hold_out", alu_out, 16'h0075);
      end
      @(negedge clk);
      in_valid = 1'b1;
      alu_in_1 = 16'hC000;
      shift    = 16'd3;
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("mid_rst_out", alu_out, 16'h0000);
      check("mid_rst_valid", {15'd0, out_valid}, 16'd0);
      rst = 1'b0;
      repeat (LAT + 1) @(negedge clk);
      check("post_rst_out", alu_out, 16'h0000);
      check("post_rst_valid", {15'd0, out_valid}, 16'd0);
      rst      = 1'b1;
      in_valid = 1'b1;
      alu_in_1 = 16'h3ABD;
      shift    = 16'd2;
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      repeat (LAT + 1) @(negedge clk);
      check("rst_drop_out", alu_out, 16'h0000);
      check("rst_drop_valid", {15'd0, out_valid}, 16'd0);
      op("first_after_rst", 16'hC000, 16'd3, 16'hF800);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/srai.md
Name: srai

Overview:
- Registered 16-bit arithmetic right-shift unit for the ALU's SRA/SRAI operations.
- Takes an operand and a shift amount and returns the operand shifted right, with the sign bit replicated into the vacated MSBs.
- Sits after operand select in the execute stage, with fixed latency and a valid strobe alongside the data.
- Implemented as a log2 barrel shifter: stages of 1, 2, 4 and 8 bit positions.

Parameters:
- DATA_W, 16, operand/result width; must be a power of two, at least 4.
- SHAMT_W, 4, number of low shift bits that drive the barrel stages; equals log2(DATA_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies shift/alu_in_1 this cycle.
- shift  input  DATA_W  shift amount, unsigned.
- alu_in_1  input  DATA_W  operand, two's complement.
- alu_out  output  DATA_W  registered shift result.
- out_valid  output  1  alu_out holds a new result.

Behaviour:
- Result = alu_in_1 >>> shift (arithmetic right shift); vacated MSBs take alu_in_1[DATA_W-1].
- Shift amount:
  - If shift[DATA_W-1:SHAMT_W] is nonzero (shift >= DATA_W), result is all copies of the sign bit: 0xFFFF if negative, 0x0000 otherwise.
  - Otherwise shift by shift[SHAMT_W-1:0]; shift 0 passes the operand through unchanged.
- Barrel stage k (weight 2^k) is enabled by shift[k]; each stage fills with the original sign bit.
- Latency, default build: inputs sampled on a rising edge appear on alu_out/out_valid after that edge (1 cycle).
- Valid handling:
  - out_valid is in_valid delayed by the latency.
  - alu_out updates only when the corresponding in_valid was 1, otherwise it holds its previous value.
- No backpressure: a new operation can be accepted every cycle, full throughput.
- Reset:
  - When rst=1 at a rising edge: alu_out=0 and out_valid=0, and all internal pipeline registers are cleared.
  - Reset wins over a simultaneous in_valid, and that operation is dropped.
  - Reset mid-pipeline discards in-flight operations; the first valid result after reset comes from the first in_valid seen after rst deasserts.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro: SRAI_PIPE2_EN.
- Defined: the barrel shifter is split into two register stages.
  - Stage 1 applies the 1- and 2-bit shifts and registers the partial result, the sign bit, the upper shift bits and the valid bit.
  - Stage 2 applies the 4- and 8-bit shifts and the >=DATA_W saturation.
  - Latency 2 cycles, throughput still 1 per cycle, and both stages clear on rst.
- Undefined: single register stage, 1-cycle latency as described above.
- The result values are identical in both builds.

Test Plan:
- Positive operand, in_valid=1, alu_in_1=0x3ABD:
  - shift=3 -> alu_out=0x0757 (0000_0111_0101_0111).
  - shift=7 -> alu_out=0x0075 (0000_0000_0111_0101).
  - shift=2 -> alu_out=0x0EAF (0000_1110_1010_1111).
  - out_valid=1 after the configured latency in each case.
- Negative operand: alu_in_1=0xC000, shift=3 -> 0xF800; alu_in_1=0x8001, shift=15 -> 0xFFFF; alu_in_1=0xF0F0, shift=0 -> 0xF0F0.
- Oversized shift:
  - alu_in_1=0x8000 with shift=16 -> 0xFFFF, and with shift=0x0100 -> 0xFFFF.
  - alu_in_1=0x3ABD with shift=16 -> 0x0000.
- Back-to-back: three consecutive valid ops (0x3ABD>>3, 0xC000>>3, 0x3ABD>>7) -> 0x0757, 0xF800, 0x0075 on consecutive cycles with out_valid held at 1.
- Hold: in_valid=0 with changing inputs -> out_valid=0 and alu_out keeps its last value.
- Reset:
  - rst=1 asserted while ops are in flight -> next cycle alu_out=0x0000, out_valid=0, and no stale result after rst drops.
  - rst and in_valid both 1 in the same cycle -> that operation is dropped.
